// File: rtl/gb_loader_pkg.sv
// Shared types and defaults for the cartridge ROM download initiator.
// Holds the FSM state encoding, pad byte and default timing parameters.
package gb_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FILL_LO,
    ST_FILL_HI,
    ST_WRITE,
    ST_GUARD,
    ST_WAIT,
    ST_TAIL,
    ST_FAIL
  } state_t;

  localparam logic [7:0]  PAD_BYTE      = 8'hFF;
  localparam int          DEF_ADDR_W    = 25;
  localparam logic [24:0] DEF_MAX_BYTES = 25'h800000;
  localparam int          DEF_SETUP_CYC = 4;
  localparam int          DEF_TAIL_CYC  = 4;
  localparam int          DEF_WAIT_TO   = 65535;

  // One shared timer serves SETUP, WAIT and TAIL; it only ever needs to reach max-1.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/gb_rom_loader_if.sv
// ioctl download bus between the ROM loader (master) and the cart block (slave).
// ioctl_wait is the slave's busy flag, raised one cycle after ioctl_wr.
interface gb_rom_loader_if
  import gb_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              cart_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [15:0]       ioctl_dout;
  logic              ioctl_wait;

  modport master (
    output cart_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait
  );

  modport slave (
    input  cart_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait
  );
endinterface

// File: rtl/gb_loader_pack.sv
// Byte-to-word packer: little-endian lo/hi byte registers, odd-length pad and remaining count.
// Registers update on the cycle after each strobe; no backpressure of its own.
module gb_loader_pack
  import gb_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] len,
  input  logic              lo_we,
  input  logic              hi_we,
  input  logic [7:0]        byte_in,
  input  logic              step,
  output logic [15:0]       word,
  output logic              odd_last,
  output logic              last_word
);

  logic [ADDR_W-1:0] rem_q;
  logic [7:0]        lo_q;
  logic [7:0]        hi_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rem_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else begin
      if (load)
        rem_q <= len;
      else if (step)
        rem_q <= (rem_q >= ADDR_W'(2)) ? rem_q - ADDR_W'(2) : '0;
      if (lo_we) begin
        lo_q <= byte_in;
        // Final byte of an odd-length image: the high half is padding.
        if (odd_last) hi_q <= PAD_BYTE;
      end
      if (hi_we)
        hi_q <= byte_in;
    end
  end

  assign word      = {hi_q, lo_q};
  assign odd_last  = (rem_q == ADDR_W'(1));
  assign last_word = (rem_q <= ADDR_W'(2));

endmodule

// File: rtl/gb_rom_loader.sv
// Cartridge download initiator: packs a byte stream into 16-bit ioctl writes to the cart block.
// Last byte to done = WRITE + GUARD + WAIT cycles + TAIL_CYC + 1; src_ready only while filling, ioctl_wait stalls.
module gb_rom_loader
  import gb_loader_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_BYTES = ADDR_W'(DEF_MAX_BYTES),
  parameter int                SETUP_CYC = DEF_SETUP_CYC,
  parameter int                TAIL_CYC  = DEF_TAIL_CYC,
  parameter int                WAIT_TO   = DEF_WAIT_TO
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  length,
  input  logic               abort,
  input  logic               src_valid,
  input  logic [7:0]         src_data,
  output logic               src_ready,
  gb_rom_loader_if.master    ioctl,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int TMR_W = tmr_width(SETUP_CYC, TAIL_CYC, WAIT_TO);

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              err_q;

  logic              len_ok;
  logic              accept;
  logic              bad_len;
  logic              lo_we;
  logic              hi_we;
  logic              step;
  logic              odd_last;
  logic              last_word;
  logic [15:0]       word;

  assign len_ok = (length != '0) && (length <= MAX_BYTES);

  gb_loader_pack #(
    .ADDR_W (ADDR_W)
  ) u_pack (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .load      (accept),
    .len       (length),
    .lo_we     (lo_we),
    .hi_we     (hi_we),
    .byte_in   (src_data),
    .step      (step),
    .word      (word),
    .odd_last  (odd_last),
    .last_word (last_word)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    accept  = 1'b0;
    bad_len = 1'b0;
    lo_we   = 1'b0;
    hi_we   = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_ok) begin
            accept  = 1'b1;
            state_d = ST_SETUP;
            tmr_d   = '0;
          end else begin
            bad_len = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_q == TMR_W'(SETUP_CYC - 1)) begin
          state_d = ST_FILL_LO;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_FILL_LO: begin
        if (src_valid) begin
          lo_we   = 1'b1;
          state_d = odd_last ? ST_WRITE : ST_FILL_HI;
        end
      end
      ST_FILL_HI: begin
        if (src_valid) begin
          hi_we   = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_GUARD;
      // The receiver's wait flag lags ioctl_wr by a cycle, so it is not trusted here.
      ST_GUARD: begin
        state_d = ST_WAIT;
        tmr_d   = '0;
      end
      ST_WAIT: begin
        if (!ioctl.ioctl_wait) begin
          step    = 1'b1;
          state_d = last_word ? ST_TAIL : ST_FILL_LO;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(WAIT_TO - 1)) begin
          state_d = ST_FAIL;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_TAIL: begin
        if (tmr_q == TMR_W'(TAIL_CYC - 1))
          state_d = ST_IDLE;
        else
          tmr_d = tmr_q + TMR_W'(1);
      end
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides every exit, including the last WAIT->TAIL and TAIL->IDLE.
    if (abort && (state_q != ST_IDLE) && (state_q != ST_FAIL))
      state_d = ST_FAIL;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      if (accept)
        addr_q <= '0;
      else if (step)
        addr_q <= addr_q + ADDR_W'(2);
      done_q <= (state_q == ST_TAIL) && (state_d == ST_IDLE);
      if (accept)
        err_q <= 1'b0;
      else if (bad_len || (state_q == ST_FAIL))
        err_q <= 1'b1;
    end
  end

  assign src_ready           = (state_q == ST_FILL_LO) || (state_q == ST_FILL_HI);
  assign ioctl.cart_download = (state_q != ST_IDLE);
  assign ioctl.ioctl_wr      = (state_q == ST_WRITE);
  assign ioctl.ioctl_addr    = addr_q;
  assign ioctl.ioctl_dout    = word;
  assign busy                = (state_q != ST_IDLE);
  assign done                = done_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_gb_rom_loader.sv
// Scoreboard bench for gb_rom_loader: stimulus pushes expected ioctl writes, a monitor pops and compares.
// The cart-side model answers each write with a programmable ioctl_wait burst and snoops the cart type byte.
module tb_gb_rom_loader;

  localparam int            AW    = 25;
  localparam int            SETUP = 4;
  localparam int            TAIL  = 4;
  localparam int            WTO   = 16;
  localparam logic [AW-1:0] MAXB  = 25'h800000;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   dout;
  } wr_t;

  logic          clk_sys   = 1'b0;
  logic          reset_n   = 1'b0;
  logic          start     = 1'b0;
  logic [AW-1:0] length    = '0;
  logic          abort     = 1'b0;
  logic          src_valid = 1'b0;
  logic [7:0]    src_data  = 8'h00;
  logic          src_ready;
  logic          busy;
  logic          done;
  logic          err;

  gb_rom_loader_if #(.ADDR_W(AW)) ioctl ();

  gb_rom_loader #(
    .ADDR_W    (AW),
    .MAX_BYTES (MAXB),
    .SETUP_CYC (SETUP),
    .TAIL_CYC  (TAIL),
    .WAIT_TO   (WTO)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .start     (start),
    .length    (length),
    .abort     (abort),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .ioctl     (ioctl),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk_sys = ~clk_sys;

  int          n_tests = 0;
  int          n_fail  = 0;
  wr_t         exp_q[$];
  logic [7:0]  src_q[$];
  logic [7:0]  img[0:511];
  int unsigned cyc = 0, src_taken = 0, wr_cnt = 0, done_cnt = 0;
  int unsigned last_wr_cyc = 0, done_cyc = 0, dl_rise_cyc = 0;
  bit          first_wr_pend = 0, have_wr = 0, saw_rdy = 0, saw_dl = 0, dl_prev = 0;
  bit          acc_pend = 0, rx_hold = 0;
  int          rx_wait = 0, rx_cnt = 0;
  logic [7:0]  cart_type = 8'h00;
  wr_t         mon_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Cart-side model: wait asserted the cycle after a write, for rx_wait cycles (or forever with rx_hold).
  always @(posedge clk_sys) begin
    if (!reset_n) begin
      ioctl.ioctl_wait <= 1'b0;
      rx_cnt           <= 0;
    end else if (ioctl.ioctl_wr) begin
      ioctl.ioctl_wait <= rx_hold || (rx_wait != 0);
      rx_cnt           <= rx_wait;
      if (ioctl.ioctl_addr == AW'('h146)) cart_type <= ioctl.ioctl_dout[15:8];
    end else if (rx_hold) begin
      ioctl.ioctl_wait <= ioctl.ioctl_wait;
    end else if (rx_cnt > 1) begin
      rx_cnt <= rx_cnt - 1;
    end else begin
      rx_cnt           <= 0;
      ioctl.ioctl_wait <= 1'b0;
    end
  end

  // Byte source: presents the queue head; a byte seen with ready at a negedge is taken on the next posedge.
  always @(negedge clk_sys) begin
    if (acc_pend) begin
      void'(src_q.pop_front());
      src_taken++;
    end
    if (src_q.size() > 0) begin
      src_valid = 1'b1;
      src_data  = src_q[0];
    end else begin
      src_valid = 1'b0;
    end
    acc_pend = src_valid && src_ready;
  end

  // Monitor / scoreboard.
  always @(negedge clk_sys) begin
    if (ioctl.cart_download && !dl_prev) begin
      dl_rise_cyc   = cyc;
      first_wr_pend = 1'b1;
    end
    dl_prev = ioctl.cart_download;
    if (src_ready) saw_rdy = 1'b1;
    if (ioctl.cart_download) saw_dl = 1'b1;
    if (ioctl.ioctl_wr) begin
      wr_cnt++;
      chk("wr_while_wait", ioctl.ioctl_wait, 0);
      if (first_wr_pend) begin
        chk("setup_window", (cyc - dl_rise_cyc) >= SETUP, 1);
        first_wr_pend = 1'b0;
      end else if (have_wr) begin
        chk("wr_spacing", (cyc - last_wr_cyc) >= 4, 1);
      end
      have_wr     = 1'b1;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wr: addr %0h dout %0h, no write expected", ioctl.ioctl_addr, ioctl.ioctl_dout);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", ioctl.ioctl_addr, mon_e.addr);
        chk("wr_dout", ioctl.ioctl_dout, mon_e.dout);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_dl_low", ioctl.cart_download, 0);
    end
  end

  // Feed nfeed image bytes to the source and expect nwords writes for an image of len bytes.
  task automatic queue_xfer(input int len, input int nfeed, input int nwords);
    wr_t e;
    for (int i = 0; i < nfeed; i++) src_q.push_back(img[i]);
    for (int w = 0; w < nwords; w++) begin
      e.addr = AW'(2 * w);
      e.dout = {(2 * w + 1 < len) ? img[2 * w + 1] : 8'hFF, img[2 * w]};
      exp_q.push_back(e);
    end
  endtask

  task automatic start_xfer(input logic [AW-1:0] len, input logic ab);
    @(negedge clk_sys);
    start  = 1'b1;
    length = len;
    abort  = ab;
    @(negedge clk_sys);
    start  = 1'b0;
    abort  = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int unsigned at_cyc);
    int i;
    i = 0;
    while (busy && i < bound) begin
      @(negedge clk_sys);
      i++;
    end
    chk("reach_idle", busy, 0);
    at_cyc = cyc;
    @(negedge clk_sys);
  endtask

  task automatic pulse_abort();
    @(negedge clk_sys);
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
  endtask

  task automatic short_ok(input string nm, input logic ab);
    int unsigned t, d0;
    img[0] = 8'h5C;
    img[1] = 8'hE7;
    d0 = done_cnt;
    queue_xfer(2, 2, 1);
    start_xfer(2, ab);
    wait_idle(200, t);
    chk({nm, "_done"}, done_cnt - d0, 1);
    chk({nm, "_err"}, err, 0);
    chk({nm, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int unsigned t, d0, w0, s0;
    int i;

    // Reset state.
    repeat (3) @(negedge clk_sys);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_dl", ioctl.cart_download, 0);
    chk("rst_wr", ioctl.ioctl_wr, 0);
    chk("rst_addr", ioctl.ioctl_addr, 0);
    chk("rst_dout", ioctl.ioctl_dout, 0);
    chk("rst_rdy", src_ready, 0);
    reset_n = 1'b1;

    // 1: four bytes, two-cycle receiver wait.
    img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
    rx_wait = 2;
    d0 = done_cnt;
    queue_xfer(4, 4, 2);
    start_xfer(4, 1'b0);
    wait_idle(300, t);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_err", err, 0);
    chk("t1_wr_to_done", done_cyc - last_wr_cyc, 1 + 2 + TAIL + 1);
    chk("t1_sb_empty", exp_q.size(), 0);

    // 2: odd length pads the high byte and leaves the spare byte in the source.
    img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD;
    rx_wait = 0;
    s0 = src_taken;
    queue_xfer(3, 4, 2);
    start_xfer(3, 1'b0);
    wait_idle(300, t);
    chk("t2_bytes_taken", src_taken - s0, 3);
    chk("t2_sb_empty", exp_q.size(), 0);
    @(posedge clk_sys);
    src_q.delete();

    // 3: header snoop of the cartridge type word.
    for (int k = 0; k < 'h150; k++) img[k] = 8'(k) ^ 8'h5A;
    img['h146] = 8'h03;
    img['h147] = 8'h1B;
    rx_wait = 1;
    queue_xfer('h150, 'h150, 'hA8);
    start_xfer(AW'('h150), 1'b0);
    wait_idle(3000, t);
    chk("t3_cart_type", cart_type, 8'h1B);
    chk("t3_mbc5", (cart_type >= 8'h19) && (cart_type <= 8'h1E), 1);
    chk("t3_sb_empty", exp_q.size(), 0);

    // 4: receiver never releases wait.
    img[0] = 8'h11; img[1] = 8'h22;
    rx_hold = 1'b1;
    d0 = done_cnt;
    queue_xfer(4, 2, 1);
    start_xfer(4, 1'b0);
    wait_idle(300, t);
    chk("t4_timeout_cycles", t - last_wr_cyc, 1 + WTO + 2);
    chk("t4_err", err, 1);
    chk("t4_no_done", done_cnt - d0, 0);
    chk("t4_dl_low", ioctl.cart_download, 0);
    chk("t4_sb_empty", exp_q.size(), 0);
    @(negedge clk_sys);
    rx_hold = 1'b0;
    rx_wait = 0;
    repeat (2) @(negedge clk_sys);

    // 5a: abort while waiting for the high byte of word 5.
    for (int k = 0; k < 16; k++) img[k] = 8'h10 + 8'(k);
    d0 = done_cnt;
    s0 = src_taken;
    queue_xfer(16, 9, 4);
    start_xfer(16, 1'b0);
    i = 0;
    while ((src_taken - s0) < 9 && i < 300) begin
      @(negedge clk_sys);
      i++;
    end
    chk("t5_fed_9", src_taken - s0, 9);
    w0 = wr_cnt;
    pulse_abort();
    wait_idle(50, t);
    repeat (4) @(negedge clk_sys);
    chk("t5_no_wr_after_abort", wr_cnt - w0, 0);
    chk("t5_err", err, 1);
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_sb_empty", exp_q.size(), 0);
    short_ok("t5a_restart", 1'b1);

    // 5b: reset during WAIT.
    img[0] = 8'h31; img[1] = 8'h32; img[2] = 8'h33; img[3] = 8'h34;
    rx_wait = 10;
    queue_xfer(4, 4, 1);
    w0 = wr_cnt;
    start_xfer(4, 1'b0);
    i = 0;
    while (wr_cnt == w0 && i < 100) begin
      @(negedge clk_sys);
      i++;
    end
    chk("t5b_first_wr", wr_cnt - w0, 1);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    chk("t5b_busy", busy, 0);
    chk("t5b_dl", ioctl.cart_download, 0);
    chk("t5b_wr", ioctl.ioctl_wr, 0);
    chk("t5b_addr", ioctl.ioctl_addr, 0);
    chk("t5b_dout", ioctl.ioctl_dout, 0);
    chk("t5b_rdy_err_done", {src_ready, err, done}, 0);
    @(posedge clk_sys);
    src_q.delete();
    exp_q.delete();
    @(negedge clk_sys);
    reset_n = 1'b1;
    rx_wait = 1;
    short_ok("t5b_restart", 1'b0);

    // 6: rejected lengths never open the window; MAX_BYTES itself is accepted.
    saw_rdy = 1'b0;
    saw_dl  = 1'b0;
    start_xfer(0, 1'b0);
    repeat (3) @(negedge clk_sys);
    chk("t6_len0_err", err, 1);
    chk("t6_len0_busy", busy, 0);
    chk("t6_len0_no_dl", saw_dl, 0);
    chk("t6_len0_no_rdy", saw_rdy, 0);
    short_ok("t6_clear", 1'b0);
    saw_rdy = 1'b0;
    saw_dl  = 1'b0;
    start_xfer(MAXB + AW'(1), 1'b0);
    repeat (3) @(negedge clk_sys);
    chk("t6_big_err", err, 1);
    chk("t6_big_busy", busy, 0);
    chk("t6_big_no_dl", saw_dl, 0);
    chk("t6_big_no_rdy", saw_rdy, 0);
    start_xfer(MAXB, 1'b0);
    chk("t6_max_busy", busy, 1);
    chk("t6_max_err_clr", err, 0);
    pulse_abort();
    wait_idle(50, t);
    chk("t6_max_abort_err", err, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gb_rom_loader.md
Name: gb_rom_loader

Overview:
- Initiator side of the cartridge download interface: takes a byte stream of a ROM image (from the SD/HPS sector path) and drives cart_download, ioctl_wr, ioctl_addr and ioctl_dout into the cart block.
- Packs bytes into little-endian 16-bit words and honours the cart block's ioctl_wait back-pressure.
- Sits between the image source and the Game Boy cart/header-parse logic, which snoops the header words at 0x142–0x14A.

Parameters:
ADDR_W, 25, width of ioctl_addr (byte address).
MAX_BYTES, 25'h800000, largest accepted image (8 MB); larger lengths are rejected.
SETUP_CYC, 4, cycles cart_download is high before the first ioctl_wr.
TAIL_CYC, 4, cycles cart_download stays high after the last write completes.
WAIT_TO, 65535, maximum cycles tolerated in ioctl_wait before abort.

Ports:
clk_sys  in  1  system clock.
reset_n  in  1  synchronous, active-low reset.
start  in  1  one-cycle request; accepted only in IDLE.
length  in  ADDR_W  image length in bytes, sampled with start.
abort  in  1  cancel the transfer at any time.
src_valid  in  1  src_data holds a byte.
src_data  in  8  image byte, in address order.
src_ready  out  1  byte accepted when src_valid&src_ready.
cart_download  out  1  download window to the cart block.
ioctl_wr  out  1  one-cycle write strobe.
ioctl_addr  out  ADDR_W  even byte address of the word.
ioctl_dout  out  16  {byte[a+1], byte[a]}.
ioctl_wait  in  1  cart block busy, registered one cycle after ioctl_wr.
busy  out  1  not in IDLE.
done  out  1  one-cycle pulse on successful completion.
err  out  1  sticky until next accepted start: bad length, abort or timeout.

Behaviour:
- Reset (reset_n=0 at a clock edge), regardless of state, forces:
  - all outputs 0, state IDLE, counters 0;
  - cart_download drops to 0 at the same edge (no tail).
- States: IDLE, SETUP, FILL_LO, FILL_HI, WRITE, GUARD, WAIT, TAIL, FAIL.
- IDLE:
  - On start with 0 < length ≤ MAX_BYTES: latch length, clear err and addr, go to SETUP.
  - On start with length = 0 or length > MAX_BYTES: set err, stay in IDLE, never assert cart_download.
- SETUP:
  - cart_download=1 from the cycle after start acceptance.
  - Hold SETUP_CYC cycles, then FILL_LO. This lets the receiver see the rising edge and clear its header state.
- FILL_LO / FILL_HI:
  - src_ready=1 only in these states.
  - The byte accepted in FILL_LO goes to dout[7:0]; the byte accepted in FILL_HI goes to dout[15:8].
  - If the remaining byte count is 1 after the FILL_LO byte, skip FILL_HI and set dout[15:8]=8'hFF (odd-length pad).
- WRITE:
  - ioctl_wr=1 for exactly one cycle, with ioctl_addr and ioctl_dout stable.
  - Next state is GUARD.
- GUARD:
  - One cycle in which ioctl_wait is ignored, because the receiver raises it one cycle after ioctl_wr.
  - Next state is WAIT.
- WAIT:
  - Remain while ioctl_wait=1.
  - When ioctl_wait=0: addr += 2, remaining -= 2 (saturating at 0). Go to FILL_LO if remaining > 0, else TAIL.
  - ioctl_addr and ioctl_dout stay unchanged from WRITE until this transition.
- Timeout: the timeout counter counts cycles in WAIT. Reaching WAIT_TO goes to FAIL.
- TAIL: hold cart_download=1 for TAIL_CYC cycles, then drop it, pulse done, go to IDLE.
- abort in any non-IDLE state goes to FAIL.
  - An ioctl_wr already issued completes naturally; none is suppressed mid-cycle.
  - abort in IDLE has no effect.
- FAIL: set err, drop cart_download next cycle, go to IDLE, no done pulse.
- Guarantees:
  - ioctl_wr is never issued while ioctl_wait=1 or during GUARD.
  - At least 3 cycles separate consecutive ioctl_wr pulses.
- start while busy is ignored.
- Simultaneous start and abort in IDLE: start wins.
- Simultaneous abort and the final WAIT exit: abort wins, so err=1 and done=0.
- Address arithmetic is ADDR_W bits. The largest address written is MAX_BYTES−2, so the address never wraps.
- Latency from the last byte accepted to done:
  - 1 (WRITE) + 1 (GUARD) + wait cycles + TAIL_CYC + 1.

Decomposition:
- Shared package gb_loader_pkg holds:
  - the state enum;
  - the pad byte constant 8'hFF;
  - default MAX_BYTES, SETUP_CYC, TAIL_CYC and WAIT_TO.
- One sub-module, gb_loader_pack: the byte-to-word packer.
  - Contains the lo/hi registers, pad insertion and remaining-count logic.
  - FSM, timers and the ioctl handshake stay in the top module.

Test Plan:
1. length=4, bytes 01 02 03 04, receiver wait for 2 cycles after each write. Expect:
   - writes (addr 0, dout 0x0201) and (addr 2, dout 0x0403);
   - ≥3 cycles between strobes;
   - cart_download high SETUP_CYC cycles before the first wr and TAIL_CYC cycles after the last;
   - done pulses once.
2. length=3, bytes AA BB CC. Expect the second write to be (addr 2, dout 0xFFCC) and no extra byte consumed from the source.
3. length=0x150, header bytes 0x146=03 and 0x147=1B. Expect the word at addr 0x146 to be 0x1B03, and the receiver to report an MBC5 type.
4. Hold ioctl_wait=1 indefinitely with WAIT_TO=16. Expect FAIL after 16 WAIT cycles, err=1, cart_download falling, no done, busy low.
5. abort asserted during FILL_HI of word 5, and reset_n=0 during WAIT in a separate run. Expect:
   - abort: no further ioctl_wr, err=1;
   - reset: all outputs 0 on the next edge;
   - in both cases a subsequent start with length=2 completes normally.
6. start with length=0, and separately length=MAX_BYTES+1. Expect err=1, no cart_download, and src_ready never asserted.
